// File: rtl/modulator_pkg.sv
// ============================================================================
// Module   : modulator_pkg
// Brief    : Phase types, FSM encoding and reference-carrier helper shared by
//            the QPSK modulator and demodulator so both ends agree on phases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package modulator_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int NUM_PHASES = 4;

    // Reference carrier k is a square wave advanced by k quarter periods.
    function automatic logic ref_bit(input int k, input int n, input int sps);
        return ((n + k * sps / 4) % sps) < (sps / 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/qpsk_symbol_demod_phase_correlator.sv
// ============================================================================
// Module   : phase_correlator
// Brief    : Match counter of the sampled carrier against one reference phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_correlator
    import modulator_pkg::*;
#(
    parameter int SPS     = 8,
    parameter int PHASE   = 0,
    parameter int IDX_W   = 3,
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_accum,
    input  logic [IDX_W-1:0]   i_index,
    input  logic               i_rx_bit,
    output logic [SCORE_W-1:0] o_score_final
);

    logic               w_ref;
    logic               w_match;
    logic [SCORE_W-1:0] r_score;

    assign w_ref   = ref_bit(PHASE, int'(i_index), SPS);
    assign w_match = (i_rx_bit == w_ref);

    // Score including the current sample, so the last sample of a symbol can
    // feed the decision without an extra pipeline stage.
    assign o_score_final = r_score + SCORE_W'(w_match);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_score <= '0;
        end else if (i_load) begin
            r_score <= SCORE_W'(w_match);
        end else if (i_accum) begin
            r_score <= o_score_final;
        end
    end

endmodule

`default_nettype wire

// File: rtl/qpsk_symbol_demod.sv
// ============================================================================
// Module   : qpsk_symbol_demod
// Brief    : Correlating QPSK symbol demodulator with valid/ready output
//            register. Define DEMOD_SCORE_EN to add the sym_score output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qpsk_symbol_demod
    import modulator_pkg::*;
#(
    parameter int SPS       = 8,
    parameter int MIN_SCORE = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       sym_start,
    input  logic                       sample_valid,
    input  logic                       rx_bit,
    output logic                       sym_valid,
    input  logic                       sym_ready,
    output logic [1:0]                 sym_data,
    output logic                       sym_err,
`ifdef DEMOD_SCORE_EN
    output logic [$clog2(SPS+1)-1:0]   sym_score,
`endif
    output logic                       overrun
);

    localparam int c_SW = $clog2(SPS + 1);
    localparam int c_IW = $clog2(SPS);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(SPS - 1);
    localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);
    localparam logic [0:0] c_ST_IDLE  = IDLE;
    localparam logic [0:0] c_ST_ACCUM = ACCUM;

    logic [0:0]       r_state;
    logic [c_IW-1:0]  r_index;

    logic             w_restart;
    logic             w_in_accum;
    logic             w_at_last;
    logic             w_accum;
    logic             w_decide;
    logic             w_clear;

    logic [c_SW-1:0]  w_final [NUM_PHASES];
    logic [c_SW-1:0]  w_best_score;
    phase_t           w_best_phase;
    logic             w_best_err;

    logic             r_sym_valid;
    phase_t           r_sym_data;
    logic             r_sym_err;
    logic             r_overrun;

    // Any accepted sym_start begins a fresh symbol, regardless of state.
    assign w_restart  = enable && sample_valid && sym_start;
    assign w_in_accum = (r_state == c_ST_ACCUM) && enable && sample_valid && !sym_start;
    assign w_at_last  = (r_index == c_LAST);
    assign w_accum    = w_in_accum && !w_at_last;
    assign w_decide   = w_in_accum && w_at_last;
    assign w_clear    = !enable || w_decide;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_index <= '0;
        end else if (!enable) begin
            r_state <= c_ST_IDLE;
            r_index <= '0;
        end else if (w_restart) begin
            r_state <= c_ST_ACCUM;
            r_index <= c_ONE;
        end else if (w_in_accum) begin
            r_index <= w_at_last ? '0 : r_index + c_ONE;
        end
    end

    generate
        for (genvar gk = 0; gk < NUM_PHASES; gk++) begin : g_phase
            phase_correlator #(
                .SPS     (SPS),
                .PHASE   (gk),
                .IDX_W   (c_IW),
                .SCORE_W (c_SW)
            ) u_corr (
                .clk           (clk),
                .rst           (rst),
                .i_clear       (w_clear),
                .i_load        (w_restart),
                .i_accum       (w_accum),
                .i_index       (r_index),
                .i_rx_bit      (rx_bit),
                .o_score_final (w_final[gk])
            );
        end
    endgenerate

    // Strict greater-than keeps the lowest phase on ties.
    always_comb begin
        w_best_score = w_final[0];
        w_best_phase = phase_t'(0);
        for (int k = 1; k < NUM_PHASES; k++) begin
            if (w_final[k] > w_best_score) begin
                w_best_score = w_final[k];
                w_best_phase = phase_t'(k);
            end
        end
    end

    assign w_best_err = (int'(w_best_score) < MIN_SCORE);

`ifdef DEMOD_SCORE_EN
    logic [c_SW-1:0] r_sym_score;
    assign sym_score = r_sym_score;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sym_valid <= 1'b0;
            r_sym_data  <= '0;
            r_sym_err   <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef DEMOD_SCORE_EN
            r_sym_score <= '0;
`endif
        end else begin
            r_overrun <= 1'b0;
            if (w_decide) begin
                if (!r_sym_valid || sym_ready) begin
                    r_sym_valid <= 1'b1;
                    r_sym_data  <= w_best_phase;
                    r_sym_err   <= w_best_err;
`ifdef DEMOD_SCORE_EN
                    r_sym_score <= w_best_score;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_sym_valid && sym_ready) begin
                r_sym_valid <= 1'b0;
            end
        end
    end

    assign sym_valid = r_sym_valid;
    assign sym_data  = r_sym_data;
    assign sym_err   = r_sym_err;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_qpsk_symbol_demod.sv
// ============================================================================
// Module   : tb_qpsk_symbol_demod
// Brief    : Self-checking bench for qpsk_symbol_demod (SPS=8, MIN_SCORE=6).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qpsk_symbol_demod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       sym_start = 1'b0;
    logic       sample_valid = 1'b0;
    logic       rx_bit = 1'b0;
    logic       sym_valid;
    logic       sym_ready = 1'b1;
    logic [1:0] sym_data;
    logic       sym_err;
    logic       overrun;
`ifdef DEMOD_SCORE_EN
    logic [3:0] sym_score;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    qpsk_symbol_demod #(.SPS(8), .MIN_SCORE(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sym_start    (sym_start),
        .sample_valid (sample_valid),
        .rx_bit       (rx_bit),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_data     (sym_data),
        .sym_err      (sym_err),
`ifdef DEMOD_SCORE_EN
        .sym_score    (sym_score),
`endif
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pat;
        bit         start;
        int         data;
        int         err;
        int         score;
    } vec_t;

    vec_t vecs[10];
    logic [7:0] refs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_sample(input bit start, input logic b);
        sample_valid = 1'b1;
        sym_start    = start;
        rx_bit       = b;
        tick();
        sample_valid = 1'b0;
        sym_start    = 1'b0;
    endtask

    // Samples first..last of pat (bit 7 is n=0), optional idle gap between them.
    task automatic send_bits(input logic [7:0] pat, input int first, input int last,
                             input bit start, input int gap);
        for (int i = first; i <= last; i++) begin
            drive_sample(start && (i == first), pat[7-i]);
            if (gap > 0 && i < last) repeat (gap) tick();
        end
    endtask

    // Reference model: score is the count of agreeing samples per phase.
    task automatic model(input logic [7:0] pat, output int d, output int e, output int s);
        int sc;
        d = 0;
        s = -1;
        for (int k = 0; k < 4; k++) begin
            sc = 8 - $countones(pat ^ refs[k]);
            if (sc > s) begin
                s = sc;
                d = k;
            end
        end
        e = (s < 6) ? 1 : 0;
    endtask

    task automatic check_sym(input string name, input int d, input int e, input int s);
        check({name, ".valid"}, int'(sym_valid), 1);
        check({name, ".data"}, int'(sym_data), d);
        check({name, ".err"}, int'(sym_err), e);
`ifdef DEMOD_SCORE_EN
        check({name, ".score"}, int'(sym_score), s);
`else
        if (s < 0) $display("note: negative score %0d", s);
`endif
    endtask

    initial begin
        int d, e, s;
        logic [7:0] p;

        refs[0] = 8'b11110000;
        refs[1] = 8'b11000011;
        refs[2] = 8'b00001111;
        refs[3] = 8'b00111100;

        vecs[0] = '{8'b11000011, 1'b1, 1, 0, 8};
        vecs[1] = '{8'b00111100, 1'b0, 3, 0, 8};
        vecs[2] = '{8'b11110001, 1'b0, 0, 0, 7};
        vecs[3] = '{8'b11111111, 1'b0, 0, 1, 4};
        vecs[4] = '{8'b00001111, 1'b0, 2, 0, 8};
        vecs[5] = '{8'b10000011, 1'b0, 1, 0, 7};
        vecs[6] = '{8'b00000000, 1'b0, 0, 1, 4};
        vecs[7] = '{8'b11100001, 1'b0, 0, 0, 6};
        vecs[8] = '{8'b11100101, 1'b0, 0, 1, 5};
        vecs[9] = '{8'b00011110, 1'b0, 2, 0, 6};

        // Reset state
        tick();
        tick();
        check("rst.valid", int'(sym_valid), 0);
        check("rst.data", int'(sym_data), 0);
        check("rst.err", int'(sym_err), 0);
        check("rst.overrun", int'(overrun), 0);
`ifdef DEMOD_SCORE_EN
        check("rst.score", int'(sym_score), 0);
`endif
        rst = 1'b0;
        enable = 1'b1;
        tick();

        // Back-to-back table symbols, consumer always ready
        for (int i = 0; i < 10; i++) begin
            send_bits(vecs[i].pat, 0, 7, vecs[i].start, 0);
            check_sym($sformatf("vec%0d", i), vecs[i].data, vecs[i].err, vecs[i].score);
        end
        tick();
        check("drain.valid", int'(sym_valid), 0);

        // Backpressure: hold, overrun, then handshake coincident with decision
        sym_ready = 1'b0;
        send_bits(8'b11000011, 0, 7, 1'b1, 0);
        check_sym("bp.first", 1, 0, 8);
        send_bits(8'b00111100, 0, 7, 1'b0, 0);
        check("bp.overrun", int'(overrun), 1);
        check_sym("bp.held", 1, 0, 8);
        tick();
        check("bp.overrun_end", int'(overrun), 0);
        send_bits(8'b00001111, 0, 6, 1'b0, 0);
        sym_ready = 1'b1;
        send_bits(8'b00001111, 7, 7, 1'b0, 0);
        check_sym("bp.coincident", 2, 0, 8);
        check("bp.no_overrun", int'(overrun), 0);
        tick();

        // Resync at n=5 and at n=7
        send_bits(8'b11110000, 0, 4, 1'b1, 0);
        check("resync5.no_sym", int'(sym_valid), 0);
        send_bits(8'b11000011, 0, 7, 1'b1, 0);
        check_sym("resync5", 1, 0, 8);
        tick();
        send_bits(8'b11110000, 0, 6, 1'b1, 0);
        send_bits(8'b00111100, 0, 0, 1'b1, 0);
        check("resync7.no_sym", int'(sym_valid), 0);
        send_bits(8'b00111100, 1, 7, 1'b0, 0);
        check_sym("resync7", 3, 0, 8);
        tick();

        // Sample gaps of 3 cycles
        send_bits(8'b00111100, 0, 6, 1'b1, 3);
        check("gap.no_early", int'(sym_valid), 0);
        send_bits(8'b00111100, 7, 7, 1'b0, 0);
        check_sym("gap", 3, 0, 8);
        tick();

        // Reset mid-symbol loses pending output and needs a new sym_start
        sym_ready = 1'b0;
        send_bits(8'b00001111, 0, 7, 1'b1, 0);
        check_sym("rstmid.pending", 2, 0, 8);
        send_bits(8'b11000011, 0, 3, 1'b0, 0);
        rst = 1'b1;
        sample_valid = 1'b1;
        rx_bit = 1'b0;
        tick();
        rst = 1'b0;
        sample_valid = 1'b0;
        check("rstmid.valid", int'(sym_valid), 0);
        check("rstmid.data", int'(sym_data), 0);
        check("rstmid.err", int'(sym_err), 0);
        check("rstmid.overrun", int'(overrun), 0);
`ifdef DEMOD_SCORE_EN
        check("rstmid.score", int'(sym_score), 0);
`endif
        sym_ready = 1'b1;
        send_bits(8'b11000011, 0, 7, 1'b0, 0);
        tick();
        check("rstmid.no_start", int'(sym_valid), 0);

        // enable=0 mid-symbol: no decision, pending output still delivered
        sym_ready = 1'b0;
        send_bits(8'b00111100, 0, 7, 1'b1, 0);
        check_sym("en.pending", 3, 0, 8);
        send_bits(8'b11110000, 0, 3, 1'b0, 0);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        send_bits(8'b11110000, 4, 7, 1'b0, 0);
        check_sym("en.held", 3, 0, 8);
        check("en.no_overrun", int'(overrun), 0);
        sym_ready = 1'b1;
        tick();
        check("en.delivered", int'(sym_valid), 0);

        // Randomised symbols against the model
        for (int i = 0; i < 24; i++) begin
            p = 8'($urandom);
            model(p, d, e, s);
            send_bits(p, 0, 7, (i == 0) || ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 2)));
            check_sym($sformatf("rand%0d", i), d, e, s);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
